// File: rtl/hamming74_stream_encoder.sv
// Hamming(7,4) stream encoder: nibble FIFO, encoder and hold/gap output pacing.
// Optional single-bit error injection is enabled by defining HAMMING74_ERR_INJECT_EN.
module hamming74_stream_encoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_data,
`ifdef HAMMING74_ERR_INJECT_EN
  input  logic        inj_arm,
  input  logic [2:0]  inj_pos,
`endif
  output logic        in_ready,
  output logic [6:0]  out_word,
  output logic        out_valid,
  output logic        idle,
  output logic [15:0] sent_count
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_MAX   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned HOLD_LOAD = HOLD_CYCLES - 1;
  localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [6:0]        word_q, word_d;
  logic [15:0]       sent_q, sent_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [3:0]        head;
  logic [6:0]        enc_word;
  logic [6:0]        flip_mask;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = rst_n & ~full;
  assign push     = in_valid & in_ready;
  assign head     = mem_q[rd_ptr_q];

  // Codeword layout {d3,d2,d1,p4,d0,p2,p1}
  assign enc_word = {head[3], head[2], head[1],
                     head[1] ^ head[2] ^ head[3],
                     head[0],
                     head[0] ^ head[2] ^ head[3],
                     head[0] ^ head[1] ^ head[3]};

`ifdef HAMMING74_ERR_INJECT_EN
  logic arm_q, arm_d;

  assign flip_mask = (arm_q && (inj_pos != 3'd7)) ? 7'(7'd1 << inj_pos) : 7'd0;

  // Sticky arm flag: new pulses are ignored while set, cleared by the next load
  always_comb begin
    arm_d = arm_q;
    if (arm_q) begin
      if (pop) arm_d = 1'b0;
    end else if (inj_arm) begin
      arm_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) arm_q <= 1'b0;
    else        arm_q <= arm_d;
  end
`else
  assign flip_mask = 7'd0;
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_HOLD;
      S_HOLD:  if (tmr_q == '0) state_d = HAS_GAP ? S_GAP : S_IDLE;
      S_GAP:   if (tmr_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    pop    = 1'b0;
    tmr_d  = tmr_q;
    word_d = word_q;
    sent_d = sent_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          word_d = enc_word ^ flip_mask;
          tmr_d  = TMR_W'(HOLD_LOAD);
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          sent_d = sent_q + 16'd1;
          tmr_d  = TMR_W'(GAP_LOAD);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
      end
      default: ;
    endcase
  end

  // FIFO pointer and occupancy update; a pop when full does not free a push slot this cycle
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmr_q    <= '0;
      word_q   <= '0;
      sent_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmr_q    <= tmr_d;
      word_q   <= word_d;
      sent_q   <= sent_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_word   = word_q;
  assign out_valid  = (state_q == S_HOLD);
  assign idle       = ~rst_n | ((state_q == S_IDLE) & empty);
  assign sent_count = sent_q;

endmodule

// File: doc/hamming74_stream_encoder.md
Name: hamming74_stream_encoder

Overview:
- Transmit-side counterpart of the 7-bit decoder project: accepts 4-bit nibbles on a valid/ready stream and buffers them in a small FIFO.
- Encodes each nibble to a Hamming(7,4) codeword and presents it on a 7-bit parallel bus.
- Holds each codeword stable for a programmable number of cycles, then forces a gap, so the decoder's 7-bit input samples a clean, settled word.

Parameters:
- FIFO_DEPTH, 4, nibble FIFO entries; power of 2, minimum 2.
- HOLD_CYCLES, 8, cycles out_valid stays high per codeword; minimum 1.
- GAP_CYCLES, 2, cycles out_valid stays low between codewords; 0 allowed.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  nibble offered.
- in_data  input  4  nibble d[3:0].
- in_ready  output  1  FIFO not full.
- out_word  output  7  codeword; bit[k] is Hamming position k+1.
- out_valid  output  1  out_word stable and valid.
- idle  output  1  FIFO empty and FSM in IDLE.
- sent_count  output  16  codewords fully emitted; wraps modulo 2^16.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n is sampled on the rising clock edge only.
  - While rst_n=0: out_word=0, out_valid=0, in_ready=0, idle=1, sent_count=0, FIFO pointers cleared, FSM=IDLE.
  - Reset mid-HOLD discards the current word and all FIFO contents.
- Input handshake:
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - in_ready = !full; it is registered-free and derived from FIFO occupancy.
  - in_data must be stable while in_valid=1 and in_ready=0.
- FIFO:
  - Occupancy counter 0..FIFO_DEPTH with wrap-around read/write pointers.
  - Simultaneous push and pop when full is allowed: the pop frees the slot in the same cycle, but in_ready still reflects the pre-pop full state, so no push happens that cycle.
  - Push and pop together when empty: no pop occurs, because the FSM pops only a non-empty FIFO.
- Encoding:
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
  - out_word[6:0] = {d3,d2,d1,p4,d0,p2,p1}.
- FSM:
  - IDLE: if FIFO non-empty, pop, register the encoded word into out_word, load hold counter = HOLD_CYCLES-1, go HOLD.
  - HOLD: out_valid=1. Decrement the counter each cycle; at 0, increment sent_count and go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: out_valid=0 and out_word keeps its last value. Counter runs GAP_CYCLES-1 down to 0, then IDLE.
- Latency:
  - A nibble accepted at edge N into an empty FIFO with the FSM in IDLE gives out_valid=1 from edge N+1 (pop at N+1) for exactly HOLD_CYCLES cycles.
  - Back-to-back words are therefore spaced HOLD_CYCLES+GAP_CYCLES+1 cycles apart; the extra cycle is the IDLE pop cycle.
- out_word changes only on the IDLE->HOLD transition.
- idle=1 only when FSM=IDLE and the FIFO is empty.

Optional Feature:
- Macro: HAMMING74_ERR_INJECT_EN.
- When defined:
  - Extra inputs inj_arm (1 bit) and inj_pos (3 bits).
  - A rising inj_arm pulse (inj_arm=1 at any edge) sets a sticky arm flag.
  - The next IDLE->HOLD load XORs out_word bit inj_pos with 1, if inj_pos<=6, then clears the flag.
  - inj_pos=7 clears the flag with no flip.
  - Arm pulses received while the flag is already set are ignored.
- When undefined: the ports are absent and codewords are always clean.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles with in_valid=1 -> out_word=0, out_valid=0, in_ready=0, idle=1, sent_count=0; after release in_ready=1.
- Single nibble, in_data=4'b1011 -> out_word=7'b1010101, out_valid high exactly 8 cycles, then low 2 cycles, sent_count=1, idle=1.
- Burst 4'h0, 4'hF, 4'h1 with default parameters:
  - codewords 7'h00, 7'h7F, 7'b0000111 appear in order, 11 cycles apart;
  - sent_count ends at 3;
  - no word is dropped.
- Full FIFO: push 6 nibbles with in_valid held high -> in_ready drops once 4 are held and the FSM is busy; each push stalls until a pop; all 6 codewords are emitted in order.
- Reset mid-HOLD with 3 words queued -> out_valid=0 the next cycle, FIFO empty, sent_count=0, no stale word emitted afterwards.
- Injection, with HAMMING74_ERR_INJECT_EN defined: arm with inj_pos=2, send 4'b1011 -> out_word=7'b1010001; the following 4'b1011 is clean (7'b1010101). With inj_pos=7: no flip and the flag clears.
